combat_controller: RTL and testbench

- Per-frame fight sequencer and hit arbiter between the two player datapaths.
- Runs the match state machine and gates player input through `ending`.
- Resolves melee strikes and ball hits into per-player damage pulses, tracks combo counts, and declares the winner on KO.
- Sits between player1/player2 and the ball/HUD logic; clocked by frame_clk.

---
 rtl/combat_if.sv | 29 ++
 rtl/combat_controller.sv | 153 +++++++++++++++
 tb/tb_combat_controller.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/combat_if.sv
// Player/ball/HUD side bundle of the fight controller: player state and hit
// pulses in, per-frame damage, combo and match status out.
interface combat_if;
    logic       start_key;
    logic [8:0] p1_action, p2_action;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_face, p2_face;
    logic [9:0] p1_hp, p2_hp;
    logic       ball1_hit, ball2_hit;
    logic [9:0] p1_damage, p2_damage;
    logic [3:0] p1_combo, p2_combo;
    logic       ending;
    logic [1:0] match_state;
    logic [1:0] winner;

    modport master (
        output start_key, p1_action, p2_action, p1_x, p1_y, p2_x, p2_y,
               p1_face, p2_face, p1_hp, p2_hp, ball1_hit, ball2_hit,
        input  p1_damage, p2_damage, p1_combo, p2_combo, ending,
               match_state, winner
    );

    modport slave (
        input  start_key, p1_action, p2_action, p1_x, p1_y, p2_x, p2_y,
               p1_face, p2_face, p1_hp, p2_hp, ball1_hit, ball2_hit,
        output p1_damage, p2_damage, p1_combo, p2_combo, ending,
               match_state, winner
    );
endinterface

// File: rtl/combat_controller.sv
// Per-frame fight sequencer and hit arbiter: runs the match FSM, resolves
// melee strikes and ball hits into one-frame damage pulses, tracks combos.
module combat_controller #(
    parameter logic [9:0] HIT_RANGE_X  = 10'd60,
    parameter logic [9:0] HIT_RANGE_Y  = 10'd40,
    parameter logic [9:0] HIT_DMG      = 10'd8,
    parameter logic [9:0] FINISH_DMG   = 10'd20,
    parameter logic [9:0] BALL_DMG     = 10'd15,
    parameter logic [5:0] COMBO_WINDOW = 6'd40,
    parameter logic [7:0] INTRO_FRAMES = 8'd120,
    parameter logic [7:0] KO_FRAMES    = 8'd90
) (
    input  logic     frame_clk,
    input  logic     Reset,
    combat_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_INTRO, S_FIGHT, S_KO, S_DONE} state_t;

    typedef struct packed {
        logic [3:0] count;
        logic [5:0] window;
    } combo_t;

    state_t     state, state_nxt;
    logic [7:0] frame_cnt, frame_cnt_nxt;
    logic [1:0] winner_q, winner_nxt;
    logic [9:0] p1_dmg_q, p2_dmg_q;
    logic [9:0] dmg_to_p1, dmg_to_p2;
    combo_t     p1_cmb, p2_cmb, p1_cmb_nxt, p2_cmb_nxt;
    logic       p1_lands, p2_lands, ko_now, live;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? a - b : b - a;
    endfunction

    function automatic logic [9:0] strike_dmg(input logic [8:0] action);
        case (action)
            9'd100, 9'd124: return HIT_DMG;
            9'd148:         return FINISH_DMG;
            default:        return 10'd0;
        endcase
    endfunction

    function automatic logic lands(input logic [8:0] action, input logic [9:0] ax,
                                   input logic [9:0] ay, input logic aface,
                                   input logic [9:0] dx, input logic [9:0] dy);
        return (strike_dmg(action) != 10'd0)
            && (abs_diff(ax, dx) <= HIT_RANGE_X)
            && (abs_diff(ay, dy) <= HIT_RANGE_Y)
            && (aface ? (dx <= ax) : (dx >= ax));
    endfunction

    function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[10] ? 10'h3FF : s[9:0];
    endfunction

    // A landed hit beats both the idle clear and the being-hit clear.
    function automatic combo_t combo_step(input logic en, input logic hit,
                                          input logic idle, input logic hurt,
                                          input combo_t cur);
        combo_t r;
        r = cur;
        if (!en) begin
            r = '0;
        end else if (hit) begin
            r.count  = (cur.count == 4'd15) ? 4'd15 : cur.count + 4'd1;
            r.window = COMBO_WINDOW;
        end else begin
            if (cur.window != 6'd0) r.window = cur.window - 6'd1;
            if (idle || hurt || r.window == 6'd0) r.count = 4'd0;
        end
        return r;
    endfunction

    assign p1_lands  = lands(bus.p1_action, bus.p1_x, bus.p1_y, bus.p1_face, bus.p2_x, bus.p2_y);
    assign p2_lands  = lands(bus.p2_action, bus.p2_x, bus.p2_y, bus.p2_face, bus.p1_x, bus.p1_y);
    assign dmg_to_p2 = sat_add(p1_lands ? strike_dmg(bus.p1_action) : 10'd0,
                               bus.ball1_hit ? BALL_DMG : 10'd0);
    assign dmg_to_p1 = sat_add(p2_lands ? strike_dmg(bus.p2_action) : 10'd0,
                               bus.ball2_hit ? BALL_DMG : 10'd0);
    assign ko_now    = (bus.p1_hp == 10'd0) || (bus.p2_hp == 10'd0);
    // The FIGHT->KO edge already counts as outside the fight.
    assign live      = (state == S_FIGHT) && !ko_now;

    assign p1_cmb_nxt = combo_step(live, p1_lands, bus.p1_action <= 9'd23,
                                   dmg_to_p1 != 10'd0, p1_cmb);
    assign p2_cmb_nxt = combo_step(live, p2_lands, bus.p2_action <= 9'd23,
                                   dmg_to_p2 != 10'd0, p2_cmb);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        winner_nxt    = winner_q;
        case (state)
            S_IDLE: if (bus.start_key) begin
                state_nxt     = S_INTRO;
                frame_cnt_nxt = INTRO_FRAMES - 8'd1;
            end
            S_INTRO: if (frame_cnt == 8'd0) state_nxt = S_FIGHT;
                     else                   frame_cnt_nxt = frame_cnt - 8'd1;
            S_FIGHT: if (ko_now) begin
                state_nxt     = S_KO;
                frame_cnt_nxt = KO_FRAMES - 8'd1;
                winner_nxt    = {bus.p1_hp == 10'd0, bus.p2_hp == 10'd0};
            end
            S_KO: if (frame_cnt == 8'd0) state_nxt = S_DONE;
                  else                   frame_cnt_nxt = frame_cnt - 8'd1;
            S_DONE: if (bus.start_key) begin
                state_nxt  = S_IDLE;
                winner_nxt = 2'd0;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!Reset) begin
            state     <= S_IDLE;
            frame_cnt <= 8'd0;
            winner_q  <= 2'd0;
            p1_dmg_q  <= 10'd0;
            p2_dmg_q  <= 10'd0;
            p1_cmb    <= '0;
            p2_cmb    <= '0;
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
            winner_q  <= winner_nxt;
            p1_dmg_q  <= live ? dmg_to_p1 : 10'd0;
            p2_dmg_q  <= live ? dmg_to_p2 : 10'd0;
            p1_cmb    <= p1_cmb_nxt;
            p2_cmb    <= p2_cmb_nxt;
        end
    end

    assign bus.p1_damage   = p1_dmg_q;
    assign bus.p2_damage   = p2_dmg_q;
    assign bus.p1_combo    = p1_cmb.count;
    assign bus.p2_combo    = p2_cmb.count;
    assign bus.winner      = winner_q;
    assign bus.ending      = (state == S_FIGHT);
    assign bus.match_state = (state == S_IDLE)  ? 2'd0 :
                             (state == S_INTRO) ? 2'd1 :
                             (state == S_FIGHT) ? 2'd2 : 2'd3;

endmodule

// File: tb/tb_combat_controller.sv
// Directed bench for combat_controller: match flow, strikes, trades, combos,
// KO/winner and asynchronous abort, each against hand-computed outputs.
module tb_combat_controller;
    logic frame_clk;
    logic Reset;
    int   tests_run;
    int   tests_failed;

    combat_if bus();

    combat_controller dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    initial begin
        frame_clk = 1'b0;
        forever #5 frame_clk = ~frame_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Output snapshot: {p1_damage, p2_damage, p1_combo, p2_combo, ending, match_state, winner}
    logic [32:0] obs;
    assign obs = {bus.p1_damage, bus.p2_damage, bus.p1_combo, bus.p2_combo,
                  bus.ending, bus.match_state, bus.winner};

    function automatic logic [32:0] pack(input logic [9:0] d1, input logic [9:0] d2,
                                         input logic [3:0] c1, input logic [3:0] c2,
                                         input logic e, input logic [1:0] ms,
                                         input logic [1:0] w);
        return {d1, d2, c1, c2, e, ms, w};
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic start_match();
        bus.start_key = 1'b1;
        tick();
        bus.start_key = 1'b0;
        repeat (120) tick();
    endtask

    task automatic finish_match();
        bus.p1_hp = 10'd100;
        bus.p2_hp = 10'd100;
        repeat (90) tick();
        bus.start_key = 1'b1;
        tick();
        bus.start_key = 1'b0;
    endtask

    task automatic test_reset();
        logic [32:0] exp;
        Reset = 1'b0;
        bus.start_key = 1'b0;
        bus.p1_action = 9'd30;   bus.p2_action = 9'd30;
        bus.p1_x = 10'd300;      bus.p1_y = 10'd300;
        bus.p2_x = 10'd350;      bus.p2_y = 10'd310;
        bus.p1_face = 1'b0;      bus.p2_face = 1'b1;
        bus.p1_hp = 10'd100;     bus.p2_hp = 10'd100;
        bus.ball1_hit = 1'b0;    bus.ball2_hit = 1'b0;
        repeat (3) tick();
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL reset_state: got %h expected %h", obs, exp); tests_failed++;
        end
        Reset = 1'b1;
    endtask

    task automatic test_intro();
        logic [32:0] exp;
        bus.start_key = 1'b1;
        tick();
        bus.start_key = 1'b0;
        exp = pack(0, 0, 0, 0, 0, 1, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL intro_enter: got %h expected %h", obs, exp); tests_failed++;
        end
        repeat (119) tick();
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL intro_hold_119: got %h expected %h", obs, exp); tests_failed++;
        end
        tick();
        exp = pack(0, 0, 0, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL fight_live_at_120: got %h expected %h", obs, exp); tests_failed++;
        end
    endtask

    task automatic test_strike();
        logic [32:0] exp;
        bus.p1_action = 9'd100;
        tick();
        exp = pack(0, 8, 1, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL strike_in_range: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p1_action = 9'd30;
        tick();
        exp = pack(0, 0, 1, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL strike_one_frame: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p2_x = 10'd370; bus.p1_action = 9'd100;
        tick();
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL strike_out_of_range_x: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p2_x = 10'd350; bus.p1_face = 1'b1;
        tick();
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL strike_wrong_facing: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p1_face = 1'b0; bus.p2_x = 10'd360; bus.p2_y = 10'd340;
        tick();
        exp = pack(0, 8, 2, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL strike_range_boundary: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p2_y = 10'd341;
        tick();
        exp = pack(0, 0, 2, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL strike_just_outside_y: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p1_action = 9'd5; bus.p2_x = 10'd350; bus.p2_y = 10'd310;
        tick();
        exp = pack(0, 0, 0, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL combo_idle_clear: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p1_action = 9'd30;
    endtask

    task automatic test_trade();
        logic [32:0] exp;
        bus.p1_action = 9'd148; bus.p2_action = 9'd148; bus.ball2_hit = 1'b1;
        tick();
        exp = pack(35, 20, 1, 1, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL trade_finishers_ball: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p1_action = 9'd30; bus.p2_action = 9'd30; bus.ball2_hit = 1'b0;
        bus.ball1_hit = 1'b1;
        tick();
        exp = pack(0, 15, 1, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL ball_only_hit: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.ball1_hit = 1'b0; bus.p2_face = 1'b0; bus.p2_action = 9'd100;
        tick();
        exp = pack(0, 0, 1, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL p2_wrong_facing: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p2_face = 1'b1; bus.p2_action = 9'd30;
    endtask

    task automatic test_combo();
        logic [32:0] exp;
        bus.p1_action = 9'd5;
        tick();
        bus.p1_action = 9'd100;
        tick();
        exp = pack(0, 8, 1, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL combo_t0: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p1_action = 9'd30;
        repeat (19) tick();
        bus.p1_action = 9'd100;
        tick();
        exp = pack(0, 8, 2, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL combo_t20: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p1_action = 9'd30;
        repeat (39) tick();
        exp = pack(0, 0, 2, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL combo_t59_held: got %h expected %h", obs, exp); tests_failed++;
        end
        tick();
        exp = pack(0, 0, 0, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL combo_t60_expired: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p1_action = 9'd100;
        tick();
        bus.p1_action = 9'd30; bus.p2_action = 9'd100;
        tick();
        exp = pack(8, 0, 0, 1, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL combo_hurt_clear: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.p2_action = 9'd30; bus.p1_action = 9'd124;
        repeat (16) tick();
        exp = pack(0, 8, 15, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL combo_reach_15: got %h expected %h", obs, exp); tests_failed++;
        end
        tick();
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL combo_saturate: got %h expected %h", obs, exp); tests_failed++;
        end
    endtask

    task automatic test_ko();
        logic [32:0] exp;
        // p1 is still striking in range: no damage may appear on the KO edge.
        bus.p2_hp = 10'd0; bus.start_key = 1'b1;
        tick();
        exp = pack(0, 0, 0, 0, 0, 3, 1);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL ko_p1_wins: got %h expected %h", obs, exp); tests_failed++;
        end
        for (int i = 0; i < 90; i++) begin
            tick();
            tests_run++;
            if (obs !== exp) begin
                $display("FAIL ko_start_ignored frame %0d: got %h expected %h", i, obs, exp);
                tests_failed++;
                break;
            end
        end
        tick();
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL done_to_idle: got %h expected %h", obs, exp); tests_failed++;
        end
        bus.start_key = 1'b0; bus.p1_action = 9'd30; bus.p2_hp = 10'd100;

        start_match();
        bus.p1_hp = 10'd0; bus.p2_hp = 10'd0;
        tick();
        exp = pack(0, 0, 0, 0, 0, 3, 3);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL ko_draw: got %h expected %h", obs, exp); tests_failed++;
        end
        finish_match();

        start_match();
        bus.p1_hp = 10'd0;
        tick();
        exp = pack(0, 0, 0, 0, 0, 3, 2);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL ko_p2_wins: got %h expected %h", obs, exp); tests_failed++;
        end
        finish_match();
    endtask

    task automatic test_abort();
        logic [32:0] exp;
        start_match();
        bus.p1_action = 9'd100;
        tick();
        exp = pack(0, 8, 1, 0, 1, 2, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL abort_precondition: got %h expected %h", obs, exp); tests_failed++;
        end
        #2;
        Reset = 1'b0;
        #1;
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL abort_async: got %h expected %h", obs, exp); tests_failed++;
        end
        tick();
        tests_run++;
        if (obs !== exp) begin
            $display("FAIL abort_next_edge: got %h expected %h", obs, exp); tests_failed++;
        end
        Reset = 1'b1;
        bus.p1_action = 9'd30;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_intro();
        test_strike();
        test_trade();
        test_combo();
        test_ko();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
